// File: rtl/mem_arbiter_pkg.sv
// Shared widths, defaults and owner encoding for the two-client memory arbiter.
package mem_arbiter_pkg;

  localparam int MEM_DATA_BITS = 128;
  localparam int MEM_MASK_BITS = MEM_DATA_BITS / 8;
  localparam int DEF_ADDR_BITS = 28;
  localparam int DEF_BEATS     = 4;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_t;

  // Beat counter width; a single-beat burst still needs one bit.
  function automatic int cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Two-way picker between instruction and data cache requests.
// ARB_ROUND_ROBIN_EN selects alternating priority; otherwise the data cache always wins ties.
module arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   req_ic,
  input  logic   req_dc,
  input  logic   advance,
  output owner_t pick
);

  logic favour_dc_reg;
  logic favour_dc_next;

  always_comb begin
    pick = (req_dc && (!req_ic || favour_dc_reg)) ? OWN_DC : OWN_IC;
    favour_dc_next = favour_dc_reg;
    if (advance) begin
`ifdef ARB_ROUND_ROBIN_EN
      // Hand the next tie to whoever was not granted this time.
      favour_dc_next = (pick == OWN_IC);
`else
      favour_dc_next = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) favour_dc_reg <= 1'b1;
    else       favour_dc_reg <= favour_dc_next;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction- and data-cache line traffic onto one memory port.
// Tie-break policy is chosen at build time by ARB_ROUND_ROBIN_EN (see arb_pick).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int BEATS     = DEF_BEATS,
  parameter int ADDR_BITS = DEF_ADDR_BITS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ic_req_valid,
  output logic                     ic_req_ready,
  input  logic [ADDR_BITS-1:0]     ic_req_addr,
  input  logic                     ic_req_rw,
  input  logic                     ic_req_data_valid,
  output logic                     ic_req_data_ready,
  input  logic [MEM_DATA_BITS-1:0] ic_req_data_bits,
  input  logic [MEM_MASK_BITS-1:0] ic_req_data_mask,
  output logic                     ic_resp_valid,
  output logic [MEM_DATA_BITS-1:0] ic_resp_data,
  input  logic                     dc_req_valid,
  output logic                     dc_req_ready,
  input  logic [ADDR_BITS-1:0]     dc_req_addr,
  input  logic                     dc_req_rw,
  input  logic                     dc_req_data_valid,
  output logic                     dc_req_data_ready,
  input  logic [MEM_DATA_BITS-1:0] dc_req_data_bits,
  input  logic [MEM_MASK_BITS-1:0] dc_req_data_mask,
  output logic                     dc_resp_valid,
  output logic [MEM_DATA_BITS-1:0] dc_resp_data,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [ADDR_BITS-1:0]     mem_req_addr,
  output logic                     mem_req_rw,
  output logic                     mem_req_data_valid,
  input  logic                     mem_req_data_ready,
  output logic [MEM_DATA_BITS-1:0] mem_req_data_bits,
  output logic [MEM_MASK_BITS-1:0] mem_req_data_mask,
  input  logic                     mem_resp_valid,
  input  logic [MEM_DATA_BITS-1:0] mem_resp_data
);

  localparam int CNT_W = cnt_width(BEATS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_RD_BUSY,
    S_WR_BUSY
  } state_t;

  state_t           state_reg;
  owner_t           owner_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             data_done_reg;

  owner_t pick;
  logic   advance;
  logic   own_dc;
  logic   in_grant, in_rd, in_wr, data_open;
  logic   sel_valid, sel_data_valid;
  logic   req_fire, data_fire;

  assign advance = (state_reg == S_IDLE) && (ic_req_valid || dc_req_valid) && !reset;

  arb_pick u_pick (
    .clk     (clk),
    .reset   (reset),
    .req_ic  (ic_req_valid),
    .req_dc  (dc_req_valid),
    .advance (advance),
    .pick    (pick)
  );

  // Reset gates every handshake output so nothing leaks out during the reset cycle.
  assign own_dc    = (owner_reg == OWN_DC);
  assign in_grant  = (state_reg == S_GRANT)   && !reset;
  assign in_rd     = (state_reg == S_RD_BUSY) && !reset;
  assign in_wr     = (state_reg == S_WR_BUSY) && !reset;
  assign data_open = (in_grant && !data_done_reg) || in_wr;

  assign sel_valid      = own_dc ? dc_req_valid      : ic_req_valid;
  assign sel_data_valid = own_dc ? dc_req_data_valid : ic_req_data_valid;

  assign mem_req_valid      = in_grant && sel_valid;
  assign mem_req_addr       = own_dc ? dc_req_addr      : ic_req_addr;
  assign mem_req_rw         = own_dc ? dc_req_rw        : ic_req_rw;
  assign mem_req_data_valid = data_open && sel_data_valid;
  assign mem_req_data_bits  = own_dc ? dc_req_data_bits : ic_req_data_bits;
  assign mem_req_data_mask  = own_dc ? dc_req_data_mask : ic_req_data_mask;

  assign req_fire  = mem_req_valid && mem_req_ready;
  assign data_fire = mem_req_data_valid && mem_req_data_ready;

  assign dc_req_ready      = in_grant && own_dc && mem_req_ready;
  assign ic_req_ready      = in_grant && !own_dc && mem_req_ready;
  assign dc_req_data_ready = data_open && own_dc && mem_req_data_ready;
  assign ic_req_data_ready = data_open && !own_dc && mem_req_data_ready;

  assign dc_resp_valid = in_rd && own_dc && mem_resp_valid;
  assign ic_resp_valid = in_rd && !own_dc && mem_resp_valid;
  assign dc_resp_data  = own_dc ? mem_resp_data : '0;
  assign ic_resp_data  = own_dc ? '0 : mem_resp_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      owner_reg     <= OWN_DC;
      cnt_reg       <= '0;
      data_done_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (ic_req_valid || dc_req_valid) begin
            owner_reg <= pick;
            state_reg <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (req_fire) begin
            data_done_reg <= 1'b0;
            if (mem_req_rw) begin
              state_reg <= (data_fire || data_done_reg) ? S_IDLE : S_WR_BUSY;
            end else begin
              state_reg <= S_RD_BUSY;
              cnt_reg   <= '0;
            end
          end else if (data_fire) begin
            // Write data may beat its request; remember so it is not sent twice.
            data_done_reg <= 1'b1;
          end
        end
        S_WR_BUSY: begin
          if (data_fire) state_reg <= S_IDLE;
        end
        S_RD_BUSY: begin
          if (mem_resp_valid) begin
            if (cnt_reg == CNT_W'(BEATS - 1)) begin
              cnt_reg   <= '0;
              state_reg <= S_IDLE;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboarded bench for mem_arbiter: read bursts, ties, writes, backpressure, reset mid-burst.
module tb_mem_arbiter;

  localparam int BEATS = 4;
  localparam int AW    = 28;

  logic         clk = 1'b0;
  logic         reset;
  logic         ic_req_valid, ic_req_ready, ic_req_rw, ic_req_data_valid, ic_req_data_ready;
  logic [AW-1:0] ic_req_addr;
  logic [127:0] ic_req_data_bits, ic_resp_data;
  logic [15:0]  ic_req_data_mask;
  logic         ic_resp_valid;
  logic         dc_req_valid, dc_req_ready, dc_req_rw, dc_req_data_valid, dc_req_data_ready;
  logic [AW-1:0] dc_req_addr;
  logic [127:0] dc_req_data_bits, dc_resp_data;
  logic [15:0]  dc_req_data_mask;
  logic         dc_resp_valid;
  logic         mem_req_valid, mem_req_ready, mem_req_rw, mem_req_data_valid, mem_req_data_ready;
  logic [AW-1:0] mem_req_addr;
  logic [127:0] mem_req_data_bits, mem_resp_data;
  logic [15:0]  mem_req_data_mask;
  logic         mem_resp_valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit           is_dc;
    logic [127:0] data;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [127:0] mon_data;

  logic [7:0] out_flags;
  assign out_flags = {ic_req_ready, dc_req_ready, ic_req_data_ready, dc_req_data_ready,
                      ic_resp_valid, dc_resp_valid, mem_req_valid, mem_req_data_valid};

  always #5 clk = ~clk;

  mem_arbiter #(.BEATS(BEATS), .ADDR_BITS(AW)) dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
    .ic_req_rw(ic_req_rw), .ic_req_data_valid(ic_req_data_valid),
    .ic_req_data_ready(ic_req_data_ready), .ic_req_data_bits(ic_req_data_bits),
    .ic_req_data_mask(ic_req_data_mask), .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_addr(dc_req_addr),
    .dc_req_rw(dc_req_rw), .dc_req_data_valid(dc_req_data_valid),
    .dc_req_data_ready(dc_req_data_ready), .dc_req_data_bits(dc_req_data_bits),
    .dc_req_data_mask(dc_req_data_mask), .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_rw(mem_req_rw), .mem_req_data_valid(mem_req_data_valid),
    .mem_req_data_ready(mem_req_data_ready), .mem_req_data_bits(mem_req_data_bits),
    .mem_req_data_mask(mem_req_data_mask), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data)
  );

  // Scoreboard: every beat a client sees must be the next expected one, for the right client.
  always @(negedge clk) begin
    if (!reset && (ic_resp_valid || dc_resp_valid)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: ic_valid=%0b dc_valid=%0b, required no beat",
                 ic_resp_valid, dc_resp_valid);
      end else begin
        mon_e    = exp_q.pop_front();
        mon_data = mon_e.is_dc ? dc_resp_data : ic_resp_data;
        if (dc_resp_valid !== mon_e.is_dc || ic_resp_valid !== !mon_e.is_dc || mon_data !== mon_e.data) begin
          errors++;
          $display("FAIL resp_beat: ic_valid=%0b dc_valid=%0b data=%h, required dc=%0b data=%h",
                   ic_resp_valid, dc_resp_valid, mon_data, mon_e.is_dc, mon_e.data);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ic_req_valid = 0; ic_req_addr = '0; ic_req_rw = 0; ic_req_data_valid = 0;
    ic_req_data_bits = '0; ic_req_data_mask = '0;
    dc_req_valid = 0; dc_req_addr = '0; dc_req_rw = 0; dc_req_data_valid = 0;
    dc_req_data_bits = '0; dc_req_data_mask = '0;
    mem_req_ready = 1; mem_req_data_ready = 1; mem_resp_valid = 0; mem_resp_data = '0;
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic set_req(input bit is_dc, input logic v, input logic [AW-1:0] a, input logic rw);
    if (is_dc) begin dc_req_valid = v; dc_req_addr = a; dc_req_rw = rw; end
    else       begin ic_req_valid = v; ic_req_addr = a; ic_req_rw = rw; end
  endtask

  task automatic push_beats(input bit is_dc, input logic [127:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.is_dc = is_dc;
      e.data  = base + 128'(i);
      exp_q.push_back(e);
    end
  endtask

  task automatic feed_beats(input logic [127:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      mem_resp_valid = 1;
      mem_resp_data  = base + 128'(i);
      tick();
    end
    mem_resp_valid = 0;
    mem_resp_data  = '0;
  endtask

  // Waits (bounded) for the given client's request to be accepted, then steps past that edge.
  task automatic await_fire(input bit is_dc, input string tag);
    bit ok;
    ok = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (mem_req_valid && (is_dc ? dc_req_ready : ic_req_ready)) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_fire: no request fire within 50 cycles, required a fire", tag);
    end
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    do_reset();
    @(negedge clk);
    checks++;
    if (out_flags !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: flags=%b, required 00000000", out_flags);
    end
    $display("reset: outputs idle");
  endtask

  task automatic test_dc_read();
    tick();
    set_req(1, 1, 28'h0000010, 0);
    @(negedge clk);
    checks++;
    if (mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_latency_idle: mem_req_valid=%0b, required 0", mem_req_valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({mem_req_valid, mem_req_addr, mem_req_rw, dc_req_ready, ic_req_ready} !== {1'b1, 28'h0000010, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL rd_grant: valid=%0b addr=%h rw=%0b dc_rdy=%0b ic_rdy=%0b, required 1 0000010 0 1 0",
               mem_req_valid, mem_req_addr, mem_req_rw, dc_req_ready, ic_req_ready);
    end
    tick();
    set_req(1, 0, '0, 0);
    push_beats(1, 128'hA, BEATS);
    feed_beats(128'hA, BEATS);
    // A stray beat in IDLE must reach nobody.
    mem_resp_valid = 1;
    mem_resp_data  = 128'hBAD;
    @(negedge clk);
    checks++;
    if ({mem_req_valid, ic_resp_valid, dc_resp_valid} !== 3'b000 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rd_done: req_valid=%0b ic_resp=%0b dc_resp=%0b pending=%0d, required 0 0 0 0",
               mem_req_valid, ic_resp_valid, dc_resp_valid, exp_q.size());
    end
    tick();
    mem_resp_valid = 0;
    $display("dc read 0x0000010: %0d beats", BEATS);
  endtask

  task automatic test_tie();
    do_reset();
    set_req(0, 1, 28'h20, 0);
    set_req(1, 1, 28'h30, 0);
    tick();
    @(negedge clk);
    checks++;
    if ({mem_req_addr, dc_req_ready, ic_req_ready} !== {28'h30, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL tie_winner: addr=%h dc_rdy=%0b ic_rdy=%0b, required 0000030 1 0",
               mem_req_addr, dc_req_ready, ic_req_ready);
    end
    tick();
    set_req(1, 0, '0, 0);
    push_beats(1, 128'h100, BEATS);
    feed_beats(128'h100, BEATS);
    @(negedge clk);
    checks++;
    if (mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL tie_gap: mem_req_valid=%0b, required 0", mem_req_valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({mem_req_valid, mem_req_addr, ic_req_ready} !== {1'b1, 28'h20, 1'b1}) begin
      errors++;
      $display("FAIL tie_loser: valid=%0b addr=%h ic_rdy=%0b, required 1 0000020 1",
               mem_req_valid, mem_req_addr, ic_req_ready);
    end
    tick();
    set_req(0, 0, '0, 0);
    push_beats(0, 128'h200, BEATS);
    feed_beats(128'h200, BEATS);
    $display("tie: dc 0x30 then ic 0x20");
  endtask

  task automatic test_write_delay();
    set_req(1, 1, 28'h40, 1);
    dc_req_data_mask = 16'hFFFF;
    await_fire(1, "wr");
    set_req(1, 0, '0, 0);
    @(negedge clk);
    checks++;
    if ({mem_req_valid, mem_req_data_valid} !== 2'b00) begin
      errors++;
      $display("FAIL wr_wait: req_valid=%0b data_valid=%0b, required 0 0", mem_req_valid, mem_req_data_valid);
    end
    tick();
    dc_req_data_valid = 1;
    dc_req_data_bits  = 128'hDEADBEEF_00112233_44556677_8899AABB;
    @(negedge clk);
    checks++;
    if ({mem_req_data_valid, dc_req_data_ready, mem_req_data_mask} !== {1'b1, 1'b1, 16'hFFFF} ||
        mem_req_data_bits !== 128'hDEADBEEF_00112233_44556677_8899AABB) begin
      errors++;
      $display("FAIL wr_data: valid=%0b rdy=%0b mask=%h bits=%h, required 1 1 ffff deadbeef0011223344556677_8899aabb",
               mem_req_data_valid, dc_req_data_ready, mem_req_data_mask, mem_req_data_bits);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({mem_req_data_valid, dc_req_data_ready} !== 2'b00) begin
      errors++;
      $display("FAIL wr_idle: data_valid=%0b data_rdy=%0b, required 0 0", mem_req_data_valid, dc_req_data_ready);
    end
    tick();
    dc_req_data_valid = 0;
    $display("dc write 0x40: late data, one data fire");
  endtask

  task automatic test_write_data_first();
    set_req(0, 1, 28'h48, 1);
    ic_req_data_valid = 1;
    ic_req_data_bits  = 128'h5A5A;
    mem_req_ready     = 0;
    tick();
    @(negedge clk);
    checks++;
    if ({mem_req_data_valid, ic_req_data_ready, ic_req_ready} !== 3'b110) begin
      errors++;
      $display("FAIL wf_data: data_valid=%0b data_rdy=%0b req_rdy=%0b, required 1 1 0",
               mem_req_data_valid, ic_req_data_ready, ic_req_ready);
    end
    tick();
    mem_req_ready = 1;
    @(negedge clk);
    checks++;
    if ({mem_req_data_valid, mem_req_valid, ic_req_ready} !== 3'b011) begin
      errors++;
      $display("FAIL wf_req: data_valid=%0b req_valid=%0b req_rdy=%0b, required 0 1 1",
               mem_req_data_valid, mem_req_valid, ic_req_ready);
    end
    tick();
    set_req(0, 0, '0, 0);
    @(negedge clk);
    checks++;
    if ({mem_req_valid, mem_req_data_valid} !== 2'b00) begin
      errors++;
      $display("FAIL wf_idle: req_valid=%0b data_valid=%0b, required 0 0", mem_req_valid, mem_req_data_valid);
    end
    tick();
    ic_req_data_valid = 0;
    $display("ic write 0x48: data before request");
  endtask

  task automatic test_backpressure();
    mem_req_ready = 0;
    set_req(0, 1, 28'h55, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({mem_req_valid, mem_req_addr, mem_req_rw, ic_req_ready} !== {1'b1, 28'h55, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%0b addr=%h rw=%0b rdy=%0b, required 1 0000055 0 0",
                 i, mem_req_valid, mem_req_addr, mem_req_rw, ic_req_ready);
      end
      tick();
    end
    mem_req_ready = 1;
    @(negedge clk);
    checks++;
    if (ic_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: ic_req_ready=%0b, required 1", ic_req_ready);
    end
    tick();
    set_req(0, 0, '0, 0);
    push_beats(0, 128'h300, BEATS);
    feed_beats(128'h300, BEATS);
    $display("ic read 0x55: 5 stall cycles");
  endtask

  task automatic test_reset_midburst();
    set_req(1, 1, 28'h60, 0);
    await_fire(1, "rst_rd");
    set_req(1, 0, '0, 0);
    push_beats(1, 128'h400, 2);
    feed_beats(128'h400, 2);
    reset = 1;
    mem_resp_valid = 1;
    mem_resp_data  = 128'h402;
    @(negedge clk);
    checks++;
    if (out_flags !== 8'h00) begin
      errors++;
      $display("FAIL rst_cycle: flags=%b, required 00000000", out_flags);
    end
    tick();
    reset = 0;
    mem_resp_data = 128'h403;
    @(negedge clk);
    checks++;
    if (out_flags !== 8'h00) begin
      errors++;
      $display("FAIL rst_after: flags=%b, required 00000000", out_flags);
    end
    tick();
    mem_resp_valid = 0;
    set_req(0, 1, 28'h70, 0);
    tick();
    @(negedge clk);
    checks++;
    if ({mem_req_valid, mem_req_addr, ic_req_ready} !== {1'b1, 28'h70, 1'b1}) begin
      errors++;
      $display("FAIL rst_fresh: valid=%0b addr=%h rdy=%0b, required 1 0000070 1",
               mem_req_valid, mem_req_addr, ic_req_ready);
    end
    tick();
    set_req(0, 0, '0, 0);
    push_beats(0, 128'h500, BEATS);
    feed_beats(128'h500, BEATS);
    $display("reset mid-burst: dc abandoned, ic 0x70 served");
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit who_dc;
    bit want_dc;
    do_reset();
    set_req(0, 1, 28'h80, 0);
    set_req(1, 1, 28'h90, 0);
    for (int t = 0; t < 4; t++) begin
      ok = 0;
      for (int n = 0; n < 50; n++) begin
        @(negedge clk);
        if (mem_req_valid && (ic_req_ready || dc_req_ready)) begin
          ok = 1;
          break;
        end
      end
      who_dc = dc_req_ready;
`ifdef ARB_ROUND_ROBIN_EN
      want_dc = (t % 2 == 0);
`else
      want_dc = 1'b1;
`endif
      checks++;
      if (!ok || who_dc !== want_dc) begin
        errors++;
        $display("FAIL b2b_grant%0d: granted_dc=%0b fired=%0b, required dc=%0b", t, who_dc, ok, want_dc);
      end
      tick();
      if (t == 3) begin
        set_req(0, 0, '0, 0);
        set_req(1, 0, '0, 0);
      end
      push_beats(who_dc, 128'h600 + 128'(t * 16), BEATS);
      feed_beats(128'h600 + 128'(t * 16), BEATS);
      $display("b2b transaction %0d granted to %s", t, who_dc ? "dc" : "ic");
    end
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_dc_read();
    test_tie();
    test_write_delay();
    test_write_data_first();
    test_backpressure();
    test_reset_midburst();
    test_back_to_back();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: pending=%0d, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter BEATS, default 4: read-response beats per line fill (512-bit line / 128-bit beat).
REQ-002 Parameter ADDR_BITS, default 28: beat address width, word address [29:2].
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 {ic,dc}_req_valid  input  1  client request valid (ic = instruction cache, dc = data cache).
REQ-006 {ic,dc}_req_ready  output  1  client request accepted this cycle.
REQ-007 {ic,dc}_req_addr  input  ADDR_BITS  client beat address.
REQ-008 {ic,dc}_req_rw  input  1  1 = write, 0 = read.
REQ-009 {ic,dc}_req_data_valid  input  1  write-data valid.
REQ-010 {ic,dc}_req_data_ready  output  1  write data accepted.
REQ-011 {ic,dc}_req_data_bits  input  128  write data.
REQ-012 {ic,dc}_req_data_mask  input  16  byte mask.
REQ-013 {ic,dc}_resp_valid  output  1  read beat valid to client.
REQ-014 {ic,dc}_resp_data  output  128  read beat data.
REQ-015 mem_req_valid/ready, mem_req_addr, mem_req_rw, mem_req_data_valid/ready, mem_req_data_bits, mem_req_data_mask: outputs except the readys (inputs); same widths as client side.
REQ-016 mem_resp_valid  input  1; mem_resp_data  input  128: memory read beats.

Function
REQ-017 States: IDLE, GRANT, RD_BUSY, WR_BUSY; owner register (IC/DC); beat counter ceilLog2(BEATS) bits.
REQ-018 IDLE: any client req_valid -> latch winner into owner, next GRANT; no mem output asserted in IDLE.
REQ-019 GRANT: owner's req fields and data channel drive mem ports; owner req_ready = mem_req_ready, owner data_ready = mem_req_data_ready; non-owner readys = 0.
REQ-020 Request fire = mem_req_valid && mem_req_ready; data fire = mem_req_data_valid && mem_req_data_ready.
REQ-021 GRANT, read fire -> RD_BUSY, counter = 0.
REQ-022 GRANT, write fire: data fired same or earlier cycle -> IDLE, else WR_BUSY; data fire before request fire recorded in a data_done flag.
REQ-023 WR_BUSY: forwards owner data channel only, mem_req_valid = 0; data fire -> IDLE.
REQ-024 RD_BUSY: mem_resp_valid/data routed to owner resp only; counter increments per beat; beat BEATS-1 -> IDLE same edge; counter wraps to 0.
REQ-025 Non-owner resp_valid always 0; mem_resp_valid outside RD_BUSY is dropped.
REQ-026 Minimum latency: client valid in cycle N -> mem_req_valid in N+1; next arbitration no earlier than the cycle after IDLE re-entry.
REQ-027 Simultaneous ic and dc valid in IDLE: priority per REQ-030/031; loser holds valid, served next IDLE.
REQ-028 Owner dropping req_valid in GRANT before fire -> mem_req_valid drops, state stays GRANT (client protocol violation; no recovery required).

Reset
REQ-029 reset (any state, mid-burst included): state IDLE, owner DC, counter 0, data_done 0, rr pointer favours DC; all valid/ready outputs 0 that cycle and the next; in-flight transaction abandoned.

Configuration
REQ-030 Macro ARB_ROUND_ROBIN_EN undefined: fixed priority, dc always wins ties.
REQ-031 ARB_ROUND_ROBIN_EN defined: 1-bit pointer flips to the other client on each IDLE->GRANT; tie goes to the client not last granted; single requester always wins.

Structure
REQ-032 MEM_DATA_BITS, beat address width and BEATS default live in const.vh; state encodings local.
REQ-033 One sub-module, arb_pick: 2-way picker (fixed or round-robin per macro), combinational plus pointer register.

Verification
REQ-034 dc read addr 0x0000010 alone -> mem_req_addr 0x0000010, rw 0; 4 beats 0xA..0xD appear on dc_resp only; ic_resp_valid stays 0.
REQ-035 ic and dc read same cycle, fixed priority -> dc burst completes first, ic request on mem 1 cycle after dc's 4th beat.
REQ-036 ARB_ROUND_ROBIN_EN, both continuously requesting 4 transactions -> grant order dc, ic, dc, ic.
REQ-037 dc write, data_valid 2 cycles after request fire, mask 0xFFFF -> WR_BUSY, one data fire, IDLE next cycle.
REQ-038 mem_req_ready low 5 cycles during GRANT -> mem fields stable, owner req_ready 0 until ready rises.
REQ-039 reset asserted after 2nd read beat -> all outputs 0; later beats ignored; fresh ic request served normally.
